// File: rtl/comp_pkg.sv
// Shared widths, state encoding and width helpers for the complex
// multiply/accumulate datapath (comp_mul -> comp_acc).
package comp_pkg;

    // comp_mul output width, and therefore comp_acc input width.
    localparam int IN_W_DEFAULT = 17;
    // Valid samples summed into one accumulator dump.
    localparam int LEN_DEFAULT  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    // Accumulator width that cannot overflow for len summed in_w-bit samples.
    function automatic int acc_width(input int in_w, input int len);
        return in_w + $clog2(len);
    endfunction

    // Sample counter width; it only ever holds 0 .. len-1.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/comp_acc_lane.sv
// One signed accumulator lane: sign-extends each sample, adds it to the
// running sum, and on a dump moves the final sum to a held output register.
module comp_acc_lane #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [IN_W-1:0]  sample_i,
    input  logic                    add_i,
    input  logic                    dump_i,
    input  logic                    clr_i,
    output logic signed [ACC_W-1:0] sum_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] out_q, out_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] sum;

    // The running sum is zero whenever no frame is open, so the first
    // sample of a frame needs no special load path.
    assign sample_ext = ACC_W'(sample_i);
    assign sum        = acc_q + sample_ext;
    assign sum_o      = out_q;

    // Next-state: abort clears the sum, a dump publishes it and restarts.
    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            if (dump_i) begin
                out_d = sum;
                acc_d = '0;
            end else begin
                acc_d = sum;
            end
        end
    end

    // Accumulator and held output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

endmodule

// File: rtl/comp_acc.sv
// Complex accumulator: sums LEN valid complex products into one dump,
// pulses out_valid for a cycle, and restarts with no bubble.
module comp_acc
    import comp_pkg::*;
#(
    parameter int IN_W = comp_pkg::IN_W_DEFAULT,
    parameter int LEN  = comp_pkg::LEN_DEFAULT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [IN_W-1:0]                    in_r,
    input  logic signed [IN_W-1:0]                    in_i,
    input  logic                                      in_en,
    input  logic                                      clr,
    output logic signed [comp_pkg::acc_width(IN_W, LEN)-1:0] out_r,
    output logic signed [comp_pkg::acc_width(IN_W, LEN)-1:0] out_i,
    output logic                                      out_valid,
    output logic                                      busy,
    output logic [7:0]                                frame_cnt
);

    localparam int ACC_W = acc_width(IN_W, LEN);
    localparam int CNT_W = cnt_width(LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    acc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       frame_q, frame_d;
    logic             valid_q, valid_d;
    logic             last_sample;

    // cnt is 0 in IDLE, so with LEN==1 the very first sample is also the last.
    assign last_sample = (cnt_q == LAST_CNT);

    assign busy      = (state_q == ACC);
    assign out_valid = valid_q;
    assign frame_cnt = frame_q;

    // Frame sequencing: clr beats a sample, the last sample triggers a dump.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        valid_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (in_en) begin
            if (last_sample) begin
                state_d = IDLE;
                cnt_d   = '0;
                frame_d = frame_q + 8'd1;
                valid_d = 1'b1;
            end else begin
                state_d = ACC;
                cnt_d   = cnt_q + 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    comp_acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_r (
        .clk      (clk),
        .rst      (rst),
        .sample_i (in_r),
        .add_i    (in_en),
        .dump_i   (last_sample),
        .clr_i    (clr),
        .sum_o    (out_r)
    );

    comp_acc_lane #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_i (
        .clk      (clk),
        .rst      (rst),
        .sample_i (in_i),
        .add_i    (in_en),
        .dump_i   (last_sample),
        .clr_i    (clr),
        .sum_o    (out_i)
    );

endmodule

// File: tb/tb_comp_acc.sv
// Bench for comp_acc: table of whole-frame scenarios, hand-written abort and
// reset sequences, then a long random run checked against a frame model.
module tb_comp_acc;

    localparam int IN_W  = 17;
    localparam int LEN   = 8;
    localparam int ACC_W = IN_W + $clog2(LEN);

    logic                    clk;
    logic                    rst;
    logic signed [IN_W-1:0]  in_r;
    logic signed [IN_W-1:0]  in_i;
    logic                    in_en;
    logic                    clr;
    logic signed [ACC_W-1:0] out_r;
    logic signed [ACC_W-1:0] out_i;
    logic                    out_valid;
    logic                    busy;
    logic [7:0]              frame_cnt;

    comp_acc #(
        .IN_W (IN_W),
        .LEN  (LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_r      (in_r),
        .in_i      (in_i),
        .in_en     (in_en),
        .clr       (clr),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame model: samples collected so far in the open frame and the last dump.
    longint m_sum_r, m_sum_i, m_out_r, m_out_i;
    int     m_n, m_frames;
    bit     m_valid;

    // Observations of DUT dumps for scenario-level checks.
    int     pulses, cyc;
    int     first_pulse_cyc, last_pulse_cyc;
    longint first_r, last_r, last_i;

    typedef struct {
        int r0;
        int i0;
        int step;
        int n;
        int gap;
        int exp_pulses;
        int exp_first_r;
        int exp_r;
        int exp_i;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sum_r = 0; m_sum_i = 0; m_out_r = 0; m_out_i = 0;
        m_n = 0; m_frames = 0; m_valid = 0;
    endtask

    task automatic clear_obs();
        pulses = 0; first_pulse_cyc = -1; last_pulse_cyc = -1;
        first_r = 0; last_r = 0; last_i = 0;
    endtask

    // Drive one cycle of stimulus, advance the model, compare all outputs.
    task automatic cycle(input int r, input int i, input bit en, input bit c);
        @(negedge clk);
        in_r  = IN_W'(r);
        in_i  = IN_W'(i);
        in_en = en;
        clr   = c;
        @(posedge clk);
        #1;
        cyc++;
        m_valid = 0;
        if (c) begin
            m_n = 0; m_sum_r = 0; m_sum_i = 0;
        end else if (en) begin
            m_sum_r += r;
            m_sum_i += i;
            m_n++;
            if (m_n == LEN) begin
                m_out_r  = m_sum_r;
                m_out_i  = m_sum_i;
                m_valid  = 1;
                m_frames = (m_frames + 1) % 256;
                m_n = 0; m_sum_r = 0; m_sum_i = 0;
            end
        end
        check("out_valid", longint'(out_valid), longint'(m_valid));
        check("busy", longint'(busy), longint'(m_n > 0));
        check("frame_cnt", longint'(frame_cnt), longint'(m_frames));
        check("out_r", longint'(out_r), m_out_r);
        check("out_i", longint'(out_i), m_out_i);
        if (out_valid) begin
            if (pulses == 0) begin
                first_pulse_cyc = cyc;
                first_r = longint'(out_r);
            end
            pulses++;
            last_pulse_cyc = cyc;
            last_r = longint'(out_r);
            last_i = longint'(out_i);
            $display("dump: frame_cnt=%0d out_r=%0d out_i=%0d", frame_cnt, out_r, out_i);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{r0: 48,     i0: 20,     step: 0, n: 8,  gap: 0, exp_pulses: 1, exp_first_r: 384,     exp_r: 384,     exp_i: 160};
        vecs[1] = '{r0: -65536, i0: -65536, step: 0, n: 8,  gap: 0, exp_pulses: 1, exp_first_r: -524288, exp_r: -524288, exp_i: -524288};
        vecs[2] = '{r0: 65535,  i0: 65535,  step: 0, n: 8,  gap: 0, exp_pulses: 1, exp_first_r: 524280,  exp_r: 524280,  exp_i: 524280};
        vecs[3] = '{r0: 1,      i0: 0,      step: 1, n: 8,  gap: 3, exp_pulses: 1, exp_first_r: 36,      exp_r: 36,      exp_i: 0};
        vecs[4] = '{r0: 1,      i0: 0,      step: 1, n: 16, gap: 0, exp_pulses: 2, exp_first_r: 36,      exp_r: 100,     exp_i: 0};

        cyc = 0;
        model_reset();
        clear_obs();
        rst = 1'b1; in_r = '0; in_i = '0; in_en = 1'b0; clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset out_r", longint'(out_r), 0);
        check("reset out_i", longint'(out_i), 0);
        check("reset out_valid", longint'(out_valid), 0);
        check("reset busy", longint'(busy), 0);
        check("reset frame_cnt", longint'(frame_cnt), 0);
        rst = 1'b0;

        // Whole-frame scenarios.
        for (int v = 0; v < 5; v++) begin
            int fc0;
            fc0 = int'(frame_cnt);
            clear_obs();
            for (int k = 0; k < vecs[v].n; k++) begin
                cycle(vecs[v].r0 + k * vecs[v].step, vecs[v].i0, 1'b1, 1'b0);
                if (k < vecs[v].n - 1) begin
                    for (int g = 0; g < vecs[v].gap; g++) begin
                        cycle(0, 0, 1'b0, 1'b0);
                        check($sformatf("vec%0d busy in gap", v), longint'(busy), 1);
                    end
                end
            end
            idle(2);
            check($sformatf("vec%0d pulses", v), pulses, vecs[v].exp_pulses);
            check($sformatf("vec%0d first out_r", v), first_r, vecs[v].exp_first_r);
            check($sformatf("vec%0d out_r", v), last_r, vecs[v].exp_r);
            check($sformatf("vec%0d out_i", v), last_i, vecs[v].exp_i);
            check($sformatf("vec%0d frame delta", v), (int'(frame_cnt) - fc0 + 256) % 256, vecs[v].exp_pulses);
            if (vecs[v].exp_pulses == 2)
                check($sformatf("vec%0d pulse spacing", v), last_pulse_cyc - first_pulse_cyc, LEN);
            if (v == 0)
                check("vec0 frame_cnt", longint'(frame_cnt), 1);
        end

        // clr mid-frame: the sample arriving with clr is dropped.
        clear_obs();
        for (int k = 0; k < 5; k++) cycle(10, 0, 1'b1, 1'b0);
        cycle(10, 0, 1'b1, 1'b1);
        check("clr busy", longint'(busy), 0);
        for (int k = 0; k < 8; k++) cycle(1, 0, 1'b1, 1'b0);
        idle(2);
        check("clr pulses", pulses, 1);
        check("clr out_r", last_r, 8);

        // clr on the would-be dump cycle suppresses the dump.
        clear_obs();
        for (int k = 0; k < 7; k++) cycle(5, 5, 1'b1, 1'b0);
        cycle(5, 5, 1'b1, 1'b1);
        idle(2);
        check("clr-dump pulses", pulses, 0);
        check("clr-dump out_r held", longint'(out_r), 8);

        // Asynchronous reset between edges, mid-frame.
        clear_obs();
        for (int k = 0; k < 4; k++) cycle(2, 0, 1'b1, 1'b0);
        @(negedge clk);
        in_en = 1'b0;
        clr   = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check("async rst out_r", longint'(out_r), 0);
        check("async rst out_i", longint'(out_i), 0);
        check("async rst busy", longint'(busy), 0);
        check("async rst frame_cnt", longint'(frame_cnt), 0);
        @(negedge clk);
        check("held rst busy", longint'(busy), 0);
        check("held rst out_valid", longint'(out_valid), 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) cycle(2, 0, 1'b1, 1'b0);
        idle(1);
        check("post-rst pulses", pulses, 1);
        check("post-rst out_r", last_r, 16);

        // Long random run; enough frames to wrap frame_cnt.
        clear_obs();
        for (int k = 0; k < 4000; k++) begin
            int  r, i;
            bit  en, c;
            r  = int'($urandom_range(131071)) - 65536;
            i  = int'($urandom_range(131071)) - 65536;
            en = ($urandom_range(9) < 8);
            c  = ($urandom_range(49) == 0);
            cycle(r, i, en, c);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_acc.md
Name: comp_acc

Overview:
- Downstream consumer of comp_mul.
- Takes the signed complex products (o_r/o_i) qualified by a valid strobe and accumulates LEN consecutive valid products into one complex sum (complex dot product / correlator dump).
- Emits the sum with a one-cycle valid pulse, then starts the next frame with no bubble.
- Sits between comp_mul and the result/readout logic.

Parameters:
- IN_W, 17, width of each signed input component (matches comp_mul output width).
- LEN, 8, valid samples per frame (>=1).
- ACC_W, IN_W+$clog2(LEN), accumulator/output width; derived, never overridden. Guarantees no overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_r  in  IN_W  signed real part of product.
- in_i  in  IN_W  signed imaginary part of product.
- in_en  in  1  sample valid; one sample per cycle while high.
- clr  in  1  synchronous frame abort.
- out_r  out  ACC_W  signed real sum, held until next dump.
- out_i  out  ACC_W  signed imaginary sum, held until next dump.
- out_valid  out  1  one-cycle pulse when out_r/out_i update.
- busy  out  1  high while a frame is partially accumulated (state ACC).
- frame_cnt  out  8  completed frames, wraps 255->0.

Behaviour:
- Reset (async, rst=1): acc_r/acc_i=0, sample count=0, state IDLE, out_r=out_i=0, out_valid=0, busy=0, frame_cnt=0. Outputs stay at these values while rst is held.
- Inputs are sign-extended IN_W->ACC_W before every add. Arithmetic is two's complement, no saturation.
- States: IDLE, ACC. busy = (state==ACC), registered.
- IDLE + in_en:
  - acc <= sext(in), cnt <= 1, go to ACC.
  - If LEN==1, dump instead (see dump).
- ACC + in_en, cnt < LEN-1: acc += sext(in), cnt++.
- ACC + in_en, cnt == LEN-1 (dump):
  - out <= acc + sext(in); out_valid=1 next cycle only.
  - acc <= 0, cnt <= 0, frame_cnt++, go to IDLE.
- in_en low: acc, cnt and state hold. Gaps of any length are allowed mid-frame.
- Back-to-back frames: a sample in the cycle after a dump starts a new frame (IDLE + in_en). Throughput is 1 sample/cycle, sustained.
- Latency: last sample of a frame on edge N -> out_valid high and out_r/out_i valid after edge N (one register stage).
- clr=1: acc=0, cnt=0, go to IDLE. No output update, no out_valid, frame_cnt unchanged.
  - clr and in_en in the same cycle: clr wins, sample is discarded.
  - clr on the dump cycle: clr wins, no dump.
- out_r/out_i change only on a dump, or to 0 on reset. clr does not affect them.
- Reset mid-frame: partial sum is lost, no output is produced.

Decomposition:
- Package comp_pkg:
  - IN_W default 17.
  - LEN default 8.
  - ACC_W derivation function.
  - State enum {IDLE, ACC}.
  - Shared with comp_mul's width constants.
- One natural sub-module: comp_acc_lane, a single signed accumulator with sext, add, clear and dump register. It is instantiated twice (real, imag).
- The counter, FSM and frame_cnt live in comp_acc.

Test Plan:
- Constant frame: 8 consecutive samples of 48+20j (comp_mul of (10+2j)(5+1j)) -> one out_valid pulse; out_r=384, out_i=160; frame_cnt=1.
- Extremes: 8 samples of -65536 - 65536j -> out=-524288 on both components (ACC_W=20 min, no wrap); 8 samples of 65535+65535j -> out=524280.
- Gapped input: samples 1..8 real, 0 imag, with in_en low 3 cycles between each -> out_r=36, out_i=0; busy high from the first sample until the dump; exactly one pulse.
- Back-to-back: 16 consecutive samples, 1..16 real -> two pulses 8 cycles apart; out_r=36 then 100; frame_cnt=2.
- clr mid-frame: 5 samples of 10, then clr together with a sample of 10, then 8 samples of 1 -> single out_r=8; the sample with clr is dropped; frame_cnt increments once.
- Async reset mid-frame: rst asserted between clock edges after 4 samples -> outputs and busy go to 0 immediately. After release, 8 samples of 2 -> out_r=16.
